// File: rtl/rom_byte_serializer.sv
// ---------------------------------------------------------------------------
// rom_byte_serializer
//
// Turns bytes from the rom_7 lookup into UART-style asynchronous frames:
// start bit (0), 8 data bits LSB-first, optional even parity bit, stop bit (1).
// din_ready is meant to drive the upstream counter enable, so the ROM address
// advances only when a byte is actually taken.
//
// Build option:
//   ROM_SER_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (11-bit frames).
//
// Parameters:
//   BIT_CYCLES  clk cycles per serial bit (1..255)
//   CNT_W       divider width, 2**CNT_W > BIT_CYCLES
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   din         byte to send
//   din_valid   din holds a byte
//   din_ready   serializer is idle and takes din on this edge if valid
//   sdo         registered serial output, idles high
//   busy        frame in progress
//   frame_done  one-cycle pulse in the first idle cycle after a frame
//   frame_cnt   completed frame count, wraps at 256
// ---------------------------------------------------------------------------
module rom_byte_serializer #(
    parameter int BIT_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sdo,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

`ifdef ROM_SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BIT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] div, div_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic             sdo_n, busy_n, frame_done_n;
    logic [7:0]       frame_cnt_n;
    logic             bit_end;
`ifdef ROM_SER_PARITY_EN
    logic             par, par_n;
`endif

    assign din_ready = (state == IDLE);
    assign bit_end   = (div == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sdo        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
`ifdef ROM_SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            div        <= div_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            sdo        <= sdo_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            frame_cnt  <= frame_cnt_n;
`ifdef ROM_SER_PARITY_EN
            par        <= par_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        div_n        = div;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        frame_done_n = 1'b0;
        frame_cnt_n  = frame_cnt;
`ifdef ROM_SER_PARITY_EN
        par_n        = par;
`endif

        case (state)
            IDLE: begin
                div_n     = '0;
                bit_cnt_n = '0;
                if (din_valid) begin
                    shreg_n = din;
`ifdef ROM_SER_PARITY_EN
                    // parity taken from the accepted byte, not the shifting copy
                    par_n   = ^din;
`endif
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_n   = '0;
                    state_n = DATA;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_n     = '0;
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef ROM_SER_PARITY_EN
                        state_n = PAR;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
`ifdef ROM_SER_PARITY_EN
            PAR: begin
                if (bit_end) begin
                    div_n   = '0;
                    state_n = STOP;
                end else begin
                    div_n = div + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_n        = '0;
                    state_n      = IDLE;
                    frame_done_n = 1'b1;
                    frame_cnt_n  = frame_cnt + 8'd1;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // sdo and busy are registered from the next state so they line up
        // with the state register (start bit appears the cycle after accept).
        sdo_n = 1'b1;
        case (state_n)
            START:   sdo_n = 1'b0;
            DATA:    sdo_n = shreg_n[0];
`ifdef ROM_SER_PARITY_EN
            PAR:     sdo_n = par_n;
`endif
            default: sdo_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_rom_byte_serializer.sv
module tb_rom_byte_serializer;

    localparam int BC = 4;
`ifdef ROM_SER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din;
    logic [7:0] din_man = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       sdo;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    logic       chain_on = 1'b0;
    logic [7:0] addr;
    logic [7:0] exp_cnt = 8'd0;
    logic [10:0] last_cap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // stand-in for rom_7 contents (b=0)
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h96;
    endfunction

    // upstream counter_8bit_enable with count_enb = din_ready
    always @(posedge clk) begin
        if (!chain_on)      addr <= 8'd0;
        else if (din_ready) addr <= addr + 8'd1;
    end

    assign din = chain_on ? rom_f(addr) : din_man;

    rom_byte_serializer #(.BIT_CYCLES(BC), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .sdo(sdo),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef ROM_SER_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Called at the negedge showing the first start-bit cycle; returns at the
    // negedge of the frame_done cycle.
    task automatic check_frame(input logic [7:0] b, input int chg_at, input logic [7:0] chg_val);
        logic [10:0] f;
        f = frame_of(b);
        last_cap = 11'h7FF;
        for (int c = 0; c < NB*BC; c++) begin
            if (c == chg_at) din_man = chg_val;
            if ((c % BC) == (BC / 2)) last_cap[c/BC] = sdo;
            check("sdo", {31'd0, sdo}, {31'd0, f[c/BC]});
            check("busy", {31'd0, busy}, 32'd1);
            check("ready_busy", {31'd0, din_ready}, 32'd0);
            check("done_early", {31'd0, frame_done}, 32'd0);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 8'd1;
        check("done_pulse", {31'd0, frame_done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("sdo_gap", {31'd0, sdo}, 32'd1);
        check("ready_gap", {31'd0, din_ready}, 32'd1);
        check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    endtask

    task automatic send(input logic [7:0] b);
        din_man = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(b, -1, 8'h00);
    endtask

    initial begin
        // reset held 3 cycles
        repeat (3) @(negedge clk);
        check("rst_sdo", {31'd0, sdo}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", {31'd0, din_ready}, 32'd1);
        check("idle_sdo", {31'd0, sdo}, 32'd1);

        // basic frame 0xA5
        send(8'hA5);
        check("a5_bits", {22'd0, last_cap[9:0]}, {22'd0, 10'b1101001010});
        @(negedge clk);
        check("done_once", {31'd0, frame_done}, 32'd0);
        check("cnt_hold", {24'd0, frame_cnt}, 32'd1);

        // hold-off: valid stays high while busy, din changes mid-frame
        din_man = 8'h3C;
        din_valid = 1'b1;
        @(negedge clk);
        check_frame(8'h3C, 8, 8'hFF);
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(8'hFF, -1, 8'h00);
        @(negedge clk);

        // reset during data bit 3 of 0x0F
        din_man = 8'h0F;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_bit3", {31'd0, sdo}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_sdo", {31'd0, sdo}, 32'd1);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_cnt", {24'd0, frame_cnt}, 32'd0);
        check("async_rdy", {31'd0, din_ready}, 32'd1);
        exp_cnt = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rdy_rel", {31'd0, din_ready}, 32'd1);
        check("sdo_rel", {31'd0, sdo}, 32'd1);
        send(8'h0F);

`ifdef ROM_SER_PARITY_EN
        send(8'h07);
        check("par_07", {31'd0, last_cap[9]}, 32'd1);
        send(8'h03);
        check("par_03", {31'd0, last_cap[9]}, 32'd0);
`endif

        // chain + wrap: 256 frames streamed from the ROM stand-in
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 8'd0;
        check("cnt_clr", {24'd0, frame_cnt}, 32'd0);
        chain_on = 1'b1;
        din_valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 256; f++) begin
            check_frame(rom_f(8'(f)), -1, 8'h00);
            if (f == 254) check("cnt_255", {24'd0, frame_cnt}, 32'd255);
            if (f == 255) begin
                check("cnt_wrap", {24'd0, frame_cnt}, 32'd0);
                din_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_sdo", {31'd0, sdo}, 32'd1);
        check("end_done", {31'd0, frame_done}, 32'd0);
        chain_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_byte_serializer.md
Name: rom_byte_serializer

Overview:
- Downstream stage of the rom_7 lookup; consumes its 8-bit data output c.
- Converts each byte into a UART-style asynchronous serial frame: start bit, 8 data bits LSB-first, stop bit.
- Uses a valid/ready handshake. din_ready gates the upstream counter_8bit_enable via count_enb, so the ROM address advances only when a byte is taken.

Parameters:
- BIT_CYCLES, 4, clk cycles per serial bit; legal range 1..255.
- CNT_W, 8, width of the divider counter; must satisfy 2^CNT_W > BIT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  8  byte from rom_7 output c.
- din_valid  input  1  din holds a byte to send.
- din_ready  output  1  serializer can accept a byte this cycle.
- sdo  output  1  serial data out; idles high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse when a frame completes.
- frame_cnt  output  8  count of completed frames; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: sdo=1, busy=0, frame_done=0, frame_cnt=0.
  - State IDLE; shift register, bit counter and divider cleared.
  - A reset mid-frame aborts the frame immediately; sdo returns high with no partial stop bit.
- din_ready = (state==IDLE), combinational from the state register; value 1 after reset release.
- Accept: a byte is taken on the rising edge where din_valid & din_ready.
  - din is captured into the shift register.
  - State becomes START; busy=1 from the next cycle.
  - din_valid while not ready is ignored; din is not sampled.
- States:
  - IDLE: sdo=1.
  - START: sdo=0 for BIT_CYCLES cycles.
  - DATA: sdo=shreg[0] for BIT_CYCLES cycles per bit, shifting right after each bit; exactly 8 bits.
  - PAR: optional; see Optional Feature.
  - STOP: sdo=1 for BIT_CYCLES cycles.
  - Return to IDLE.
- sdo is registered. The start bit is first visible in the cycle after the accept edge.
- Frame length is exactly 10*BIT_CYCLES cycles from the first start-bit cycle to the last stop-bit cycle (11*BIT_CYCLES with parity).
- Divider:
  - Counts 0..BIT_CYCLES-1.
  - A bit ends when divider==BIT_CYCLES-1; the divider then clears.
  - BIT_CYCLES=1 gives one bit per clk.
- Frame end, on the edge leaving STOP:
  - busy->0, frame_done=1 for exactly one cycle (the first IDLE cycle).
  - frame_cnt increments, 255 wraps to 0.
- Back-to-back: a byte can be accepted in that first IDLE cycle (din_ready=1 alongside frame_done). The next start bit then directly follows one idle-high cycle; minimum inter-frame gap is 1 clk.
- din_valid held high continuously streams bytes with that 1-cycle gap.

Optional Feature:
- Macro: ROM_SER_PARITY_EN.
- Defined:
  - PAR state inserted between DATA and STOP.
  - sdo = even parity (XOR of the 8 captured bits) for BIT_CYCLES cycles.
  - Frame length 11*BIT_CYCLES.
  - Parity is computed from the byte captured at accept, not from the shifting register.
- Undefined: no PAR state, no parity logic; 10-bit frames.

Test Plan:
- Basic frame (BIT_CYCLES=4): assert reset low 3 cycles, release, present din=8'hA5 with din_valid=1 for one cycle.
  - sdo bits, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - busy high 40 cycles; frame_done pulses once; frame_cnt=1.
- Handshake hold-off: din_valid=1 with din=8'h3C while busy, changing din to 8'hFF mid-frame.
  - First frame unaffected; 8'hFF accepted only in the frame_done cycle.
  - Gap between stop bit and next start bit is exactly 1 cycle.
- Reset mid-frame: pull reset low during data bit 3 of 8'h0F.
  - sdo=1, busy=0, frame_cnt=0 asynchronously, before the next clk edge.
  - After release, din_ready=1 and a new 8'h0F frame is correct.
- Wrap: stream 256 frames with BIT_CYCLES=1 and din_valid held high.
  - frame_cnt goes 255->0 on the 256th frame_done.
  - Each frame is 10 cycles plus a 1-cycle gap.
- Parity (ROM_SER_PARITY_EN): din=8'h07 -> parity bit 1; din=8'h03 -> parity bit 0; frames 44 cycles at BIT_CYCLES=4.
- Chain: counter_8bit_enable (count_enb=din_ready) -> rom_7 (b=0) -> serializer.
  - Serial bytes match rom_7 contents at addresses 0,1,2,... in order.
  - No address is skipped or repeated.
